// File: rtl/demux_4_route_ctrl.sv
// Wormhole route controller for one router input port.
// Requests an output, locks the demux select per packet, releases on tail.
module demux_4_route_ctrl #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [1:0]           in_type,
  input  logic [1:0]           in_dest,
  output logic                 in_ready,
  output logic [3:0]           req_o,
  input  logic [3:0]           grant_i,
  output logic [3:0]           sel_o,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic                 busy,
  output logic                 err_o,
  output logic [CNT_WIDTH-1:0] flit_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t               state_q, state_d;
  logic [1:0]           port_q, port_d;
  logic [3:0]           req_q, req_d;
  logic [3:0]           sel_q, sel_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // in_type[0] marks head/single, in_type[1] marks tail/single.
  logic is_head, is_tail, port_rdy, xfer_hs;

  assign is_head  = in_type[0];
  assign is_tail  = in_type[1];
  assign port_rdy = out_ready[port_q];
  assign xfer_hs  = in_valid & port_rdy;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    logic [3:0] v;
    v = 4'b0000;
    v[idx] = 1'b1;
    return v;
  endfunction

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      port_q  <= 2'd0;
      req_q   <= 4'b0000;
      sel_q   <= 4'b0000;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      req_q   <= req_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state plus the combinational handshake gating.
  // cnt_q is cleared on grant and never wraps, so zero
  // identifies the packet's own head in XFER.
  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    req_d     = req_q;
    sel_d     = sel_q;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 4'b0000;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_head) begin
            port_d  = in_dest;
            req_d   = onehot(in_dest);
            state_d = REQ;
          end else begin
            in_ready = 1'b1;
            err_d    = 1'b1;
          end
        end
      end
      REQ: begin
        if (grant_i[port_q]) begin
          sel_d   = onehot(port_q);
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        in_ready  = port_rdy;
        out_valid = sel_q & {4{in_valid}};
        if (xfer_hs) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
          if (is_tail) begin
            req_d   = 4'b0000;
            sel_d   = 4'b0000;
            state_d = IDLE;
          end else if (is_head && cnt_q != '0) begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_o    = req_q;
  assign sel_o    = sel_q;
  assign err_o    = err_q;
  assign flit_cnt = cnt_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_demux_4_route_ctrl.sv
// Directed bench for demux_4_route_ctrl.
// Transfers are scoreboarded; control outputs checked per step.
module tb_demux_4_route_ctrl;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [1:0]    in_type;
  logic [1:0]    in_dest;
  logic          in_ready;
  logic [3:0]    req_o;
  logic [3:0]    grant_i;
  logic [3:0]    sel_o;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic          busy;
  logic          err_o;
  logic [CW-1:0] flit_cnt;

  typedef struct {
    logic [3:0] sel;
    logic [1:0] typ;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  demux_4_route_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_type   (in_type),
    .in_dest   (in_dest),
    .in_ready  (in_ready),
    .req_o     (req_o),
    .grant_i   (grant_i),
    .sel_o     (sel_o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .err_o     (err_o),
    .flit_cnt  (flit_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] oh(input logic [1:0] d);
    logic [3:0] v;
    v = 4'b0000;
    v[d] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic half();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] d, input logic [1:0] t);
    exp_t e;
    e.sel = oh(d);
    e.typ = t;
    sb.push_back(e);
  endtask

  // Presents a head in IDLE, grant ready; returns at first XFER cycle.
  task automatic open_pkt(input logic [1:0] d, input logic [1:0] t);
    in_valid = 1'b1;
    in_type  = t;
    in_dest  = d;
    grant_i  = oh(d);
    half();
    chk("op_idle_busy", 32'(busy), 32'd0);
    chk("op_idle_rdy", 32'(in_ready), 32'd0);
    chk("op_idle_req", 32'(req_o), 32'd0);
    nxt();
    half();
    chk("op_req", 32'(req_o), 32'(oh(d)));
    chk("op_req_sel", 32'(sel_o), 32'd0);
    chk("op_req_rdy", 32'(in_ready), 32'd0);
    chk("op_req_busy", 32'(busy), 32'd1);
    nxt();
  endtask

  // Scoreboard: every output handshake must match the next expectation.
  always @(negedge clk) begin
    if (!rst && |(out_valid & out_ready)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_extra: observed %b expected none", out_valid);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_sel", 32'(out_valid), 32'(e.sel));
        chk("sb_type", 32'(in_type), 32'(e.typ));
        chk("sb_rdy", 32'(in_ready), 32'd1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] types [4];
    int idx;
    int last;
    logic rdy;
    types[0] = 2'b01;
    types[1] = 2'b00;
    types[2] = 2'b00;
    types[3] = 2'b10;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_type   = 2'b00;
    in_dest   = 2'd0;
    grant_i   = 4'b0000;
    out_ready = 4'b1111;
    nxt();
    nxt();
    half();
    chk("rst_req", 32'(req_o), 32'd0);
    chk("rst_sel", 32'(sel_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_cnt", 32'(flit_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    nxt();
    rst = 1'b0;

    // Single flit to port 2.
    push(2'd2, 2'b11);
    open_pkt(2'd2, 2'b11);
    half();
    chk("t1_sel", 32'(sel_o), 32'h4);
    chk("t1_rdy", 32'(in_ready), 32'd1);
    chk("t1_ov", 32'(out_valid), 32'h4);
    nxt();
    in_valid = 1'b0;
    grant_i  = 4'b0000;
    half();
    chk("t1_rel_sel", 32'(sel_o), 32'd0);
    chk("t1_rel_req", 32'(req_o), 32'd0);
    chk("t1_cnt", 32'(flit_cnt), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    nxt();

    // Four flits to port 1, slow grant, toggling ready.
    push(2'd1, 2'b01);
    in_valid = 1'b1;
    in_type  = 2'b01;
    in_dest  = 2'd1;
    grant_i  = 4'b1101;
    half();
    chk("t2_idle_rdy", 32'(in_ready), 32'd0);
    nxt();
    for (int w = 0; w < 5; w++) begin
      in_valid = (w != 2);
      half();
      chk("t2_wait_req", 32'(req_o), 32'h2);
      chk("t2_wait_sel", 32'(sel_o), 32'd0);
      chk("t2_wait_rdy", 32'(in_ready), 32'd0);
      chk("t2_wait_ov", 32'(out_valid), 32'd0);
      nxt();
    end
    in_valid = 1'b1;
    grant_i  = 4'b0010;
    nxt();
    grant_i = 4'b0000;
    idx  = 0;
    last = 0;
    for (int k = 0; k < 16 && idx < 4; k++) begin
      rdy = (k % 2 == 0);
      if (idx > last) begin
        push(2'd1, types[idx]);
        last = idx;
      end
      in_type   = types[idx];
      out_ready = {2'b11, rdy, 1'b1};
      half();
      chk("t2_rdy", 32'(in_ready), 32'(rdy));
      chk("t2_sel", 32'(sel_o), 32'h2);
      chk("t2_ov", 32'(out_valid), 32'h2);
      if (rdy) idx++;
      nxt();
    end
    in_valid  = 1'b0;
    out_ready = 4'b1111;
    half();
    chk("t2_rel_sel", 32'(sel_o), 32'd0);
    chk("t2_cnt", 32'(flit_cnt), 32'd4);
    chk("t2_busy", 32'(busy), 32'd0);
    nxt();

    // Stray body then tail in IDLE.
    in_valid = 1'b1;
    in_type  = 2'b00;
    half();
    chk("t3_body_rdy", 32'(in_ready), 32'd1);
    chk("t3_body_err", 32'(err_o), 32'd0);
    nxt();
    in_type = 2'b10;
    half();
    chk("t3_tail_rdy", 32'(in_ready), 32'd1);
    chk("t3_err1", 32'(err_o), 32'd1);
    chk("t3_req", 32'(req_o), 32'd0);
    nxt();
    in_valid = 1'b0;
    half();
    chk("t3_err2", 32'(err_o), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    nxt();
    half();
    chk("t3_err_end", 32'(err_o), 32'd0);
    nxt();

    // Extra head inside a packet on port 3.
    push(2'd3, 2'b01);
    open_pkt(2'd3, 2'b01);
    half();
    chk("t4_ov", 32'(out_valid), 32'h8);
    nxt();
    push(2'd3, 2'b01);
    half();
    chk("t4_err_first", 32'(err_o), 32'd0);
    chk("t4_cnt1", 32'(flit_cnt), 32'd1);
    nxt();
    in_type = 2'b00;
    push(2'd3, 2'b00);
    half();
    chk("t4_err_mid", 32'(err_o), 32'd1);
    chk("t4_busy", 32'(busy), 32'd1);
    nxt();
    in_type = 2'b10;
    push(2'd3, 2'b10);
    half();
    chk("t4_err_clr", 32'(err_o), 32'd0);
    chk("t4_sel", 32'(sel_o), 32'h8);
    nxt();
    in_valid = 1'b0;
    half();
    chk("t4_cnt", 32'(flit_cnt), 32'd4);
    chk("t4_busy_end", 32'(busy), 32'd0);
    nxt();

    // Reset mid-packet, then a fresh single flit to port 0.
    out_ready = 4'b0000;
    open_pkt(2'd3, 2'b01);
    half();
    chk("t5_sel", 32'(sel_o), 32'h8);
    chk("t5_rdy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    nxt();
    rst      = 1'b0;
    in_valid = 1'b0;
    half();
    chk("t5_rst_sel", 32'(sel_o), 32'd0);
    chk("t5_rst_req", 32'(req_o), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_cnt", 32'(flit_cnt), 32'd0);
    nxt();
    out_ready = 4'b1111;
    push(2'd0, 2'b11);
    open_pkt(2'd0, 2'b11);
    half();
    chk("t5_ov", 32'(out_valid), 32'h1);
    nxt();
    in_valid = 1'b0;
    half();
    chk("t5_cnt", 32'(flit_cnt), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    nxt();

    // 300-flit packet: counter saturates at 255.
    push(2'd0, 2'b01);
    open_pkt(2'd0, 2'b01);
    for (int i = 0; i < 300; i++) begin
      in_type = (i == 0) ? 2'b01 : (i == 299) ? 2'b10 : 2'b00;
      if (i > 0) push(2'd0, in_type);
      half();
      if (i == 100) chk("t6_cnt100", 32'(flit_cnt), 32'd100);
      if (i == 255) chk("t6_cnt255", 32'(flit_cnt), 32'd255);
      if (i == 299) chk("t6_sat", 32'(flit_cnt), 32'd255);
      nxt();
    end
    in_valid = 1'b0;
    half();
    chk("t6_cnt_end", 32'(flit_cnt), 32'd255);
    chk("t6_sel", 32'(sel_o), 32'd0);
    chk("t6_req", 32'(req_o), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("sb_left", 32'(sb.size()), 32'd0);
    nxt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_4_route_ctrl.md
Name: demux_4_route_ctrl

Overview:
- Per-input wormhole route controller that drives the one-hot select of a 4-way output demultiplexer in the router datapath.
- Decodes the destination of a head flit and requests the matching output from the switch allocator.
- Once the grant arrives, locks the select for the whole packet and gates valid/ready between the input buffer and the selected output.
- Releases the select and the request on the tail flit.

Parameters:
- CNT_WIDTH, 8, width of the per-packet flit counter exposed for debug (saturating).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input buffer has a flit
- in_type  input  2  flit type: 00 body, 01 head, 10 tail, 11 single (head+tail)
- in_dest  input  2  destination output index; sampled only on head/single
- in_ready  output  1  flit consumed this cycle when in_valid & in_ready
- req_o  output  4  one-hot output request to switch allocator
- grant_i  input  4  one-hot grant from allocator; held while req_o held
- sel_o  output  4  one-hot select to demux; 0000 when not transferring
- out_valid  output  4  per-output valid, = sel_o & {4{in_valid}} in XFER
- out_ready  input  4  per-output downstream ready
- busy  output  1  state != IDLE
- err_o  output  1  one-cycle protocol-error pulse
- flit_cnt  output  CNT_WIDTH  flits transferred in current/last packet

Behaviour:
- Reset (rst=1 at edge): state=IDLE, port=0, req_o=0000, sel_o=0000, err_o=0, flit_cnt=0. Reset mid-packet abandons the packet; no release handshake.
- Combinational outputs: out_valid, in_ready. Registered outputs: req_o, sel_o, err_o, flit_cnt, busy.
- IDLE:
  - in_valid & type head/single: latch port=in_dest, req_o<=onehot(in_dest), go REQ. Head not consumed (in_ready=0).
  - in_valid & type body/tail: in_ready=1, flit dropped, err_o<=1 next cycle; stay IDLE.
  - Otherwise in_ready=0.
- REQ:
  - req_o held; in_ready=0, out_valid=0000.
  - grant_i[port]=1: sel_o<=onehot(port), flit_cnt<=0, go XFER.
  - Grant bits on other ports are ignored.
  - in_valid dropping while in REQ does not cancel the request.
- XFER:
  - in_ready=out_ready[port]; out_valid=sel_o & {4{in_valid}}.
  - On each handshake: flit_cnt+1, saturating at all-ones.
  - Handshake on tail/single: req_o<=0000, sel_o<=0000, go IDLE.
  - Handshake on head: forwarded as body, err_o<=1, no state change.
  - A new head is never accepted in the same cycle as a tail; minimum 2 idle cycles between packets (IDLE, REQ).
- Latency:
  - Head valid in IDLE -> req_o at +1 -> grant sampled -> sel_o at grant+1 -> head transfers the same cycle if out_ready[port]=1.
  - Best case, head valid at T transfers at T+2 with grant combinationally high at T+1.
- grant_i withdrawn during XFER: ignored; the allocator must not revoke while req_o is asserted.
- err_o: high exactly one cycle per offending flit; back-to-back errors give consecutive pulses.

Test Plan:
- Reset then single flit, dest=2, grant_i=0100 at first req cycle, out_ready=1111:
  - req_o=0100 at T+1, sel_o=0100 at T+2, in_ready=1 and out_valid=0100 at T+2.
  - Back to IDLE at T+3 with sel_o=req_o=0000, flit_cnt=1.
- 4-flit packet dest=1, grant delayed 5 cycles, out_ready[1] toggling 1,0,1,0:
  - in_ready mirrors out_ready[1]; no flit transfers while out_ready[1]=0.
  - sel_o=0010 throughout; flit_cnt=4 at release.
- Body flit then tail flit presented in IDLE: each consumed with in_ready=1; err_o pulses twice in consecutive cycles; state stays IDLE; req_o=0000.
- Head arriving mid-packet in XFER: forwarded on the current port, err_o=1 for one cycle, packet continues until the tail.
- rst asserted during XFER with sel_o=1000: next cycle sel_o=0000, req_o=0000, busy=0; then a new head dest=0 is processed normally.
- 300-flit packet with CNT_WIDTH=8: flit_cnt saturates at 255, packet completes and releases normally.
